capture_ctrl: RTL and testbench
===============================

// Module: capture_ctrl
// PURPOSE
// - Sample-capture controller for the 5-channel logic analyzer. Sits beside trigger_logic:
//   produces its armed/set_capture_done inputs, consumes its triggered output.
// - Writes decimated samples into the circular sample RAM; arms the trigger once enough
//   pre-trigger history is stored; ends capture after trig_pos post-trigger samples.
// PARAMETERS
// - ENTRIES  384  sample RAM depth (words); legal 2..2**AW
// - AW       9    RAM address width
// PORTS
// - clk               in   1   system clock
// - rst_n             in   1   asynchronous, active-low reset
// - run               in   1   capture enable from command/config register (level)
// - capture_done      in   1   status flag; set by set_capture_done, cleared by host
// - wrt_smpl          in   1   one-cycle strobe: new decimated sample valid this cycle
// - triggered         in   1   latched trigger from trigger_logic
// - trig_pos          in   AW  post-trigger sample count (incl. trigger sample)
// - we                out  1   RAM write enable (combinational)
// - waddr             out  AW  RAM write address (registered)
// - armed             out  1   pre-trigger buffer filled; trigger may fire
// - set_capture_done  out  1   one-cycle pulse: capture complete
// - trig_addr         out  AW  address of last sample written (oldest = trig_addr+1 mod ENTRIES)
// BEHAVIOUR
// - Reset: state=IDLE; waddr, trig_addr, smpl_cnt, trig_cnt = 0; armed, set_capture_done = 0.
// - States: IDLE, CAPTURE, WAIT_RD.
// - IDLE: run && !capture_done -> CAPTURE; on that edge waddr, smpl_cnt, trig_cnt <= 0,
//   armed <= 0. Otherwise remain. we = 0.
// - CAPTURE: we = wrt_smpl. Only wrt_smpl cycles advance counters; gaps hold all state.
//   - Each write: waddr <= (waddr==ENTRIES-1) ? 0 : waddr+1.
//   - smpl_cnt (AW+1 bits) increments per write, saturating at ENTRIES.
//   - armed <= 1 on the write where (smpl_cnt+1) + tp_eff >= ENTRIES (AW+2-bit compare);
//     stays 1 until capture ends/aborts.
//   - tp_eff = trig_pos clamped to 1..ENTRIES-1 (0 -> 1; >=ENTRIES -> ENTRIES-1).
//   - triggered && armed && wrt_smpl: trig_cnt++. triggered while !armed is ignored.
//   - On write where trig_cnt+1 == tp_eff: trig_addr <= waddr (address just written);
//     next cycle set_capture_done = 1 for exactly one cycle, armed = 0, state -> WAIT_RD.
//   - !run (any cycle) -> IDLE next cycle, armed <= 0, no done pulse; that cycle's
//     we still follows wrt_smpl (abort takes effect after edge).
// - WAIT_RD: we = 0; waddr/trig_addr held for host readout. capture_done==0 -> IDLE.
//   Host clears capture_done at least 1 cycle after the pulse.
// - Latency: write -> waddr advance 1 clk; final write -> set_capture_done 1 clk.
// - rst_n low mid-capture: immediate return to reset values; no done pulse.
// TESTING (ENTRIES=16, AW=4)
// - Reset: rst_n=0 with run=1, wrt_smpl=1 -> we=0, armed=0, waddr=0, set_capture_done=0.
// - Arm point: trig_pos=4, wrt_smpl every clk -> armed rises after 12th write, waddr=12.
// - Full capture: trigger at write 20 (waddr 4) -> writes 20..23, done pulse 1 clk after
//   write 23, trig_addr=7, state WAIT_RD, we=0; waddr wraps 15->0 en route.
// - Early trigger: triggered=1 from cycle 0 -> trig_cnt stays 0 until armed; done after
//   writes 12..15, trig_addr=15.
// - Sparse strobes: wrt_smpl every 3rd clk -> counters/addr advance only on strobes.
// - Abort/restart: run=0 at write 8 -> IDLE, armed=0, no pulse; WAIT_RD holds with
//   capture_done=1 even if run=1; clear -> IDLE -> CAPTURE restarts at waddr=0.

Source files
------------

// File: rtl/capture_ctrl.sv
// capture_ctrl: sample-capture controller for the 5-channel logic analyzer.
// Streams decimated samples into a circular RAM, arms the trigger once enough
// pre-trigger history is stored, and ends the capture after the requested
// number of post-trigger samples. Pairs with trigger_logic (armed / triggered /
// set_capture_done handshake).
module capture_ctrl #(
    parameter int ENTRIES = 384,
    parameter int AW      = 9
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          run,
    input  logic          capture_done,
    input  logic          wrt_smpl,
    input  logic          triggered,
    input  logic [AW-1:0] trig_pos,
    output logic          we,
    output logic [AW-1:0] waddr,
    output logic          armed,
    output logic          set_capture_done,
    output logic [AW-1:0] trig_addr
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        WAIT_RD = 2'd2
    } state_t;

    // Depth constants at the widths they are compared against
    localparam logic [AW+1:0] LP_ENT2 = (AW+2)'(ENTRIES);
    localparam logic [AW:0]   LP_ENT1 = (AW+1)'(ENTRIES);
    localparam logic [AW-1:0] LP_LAST = AW'(ENTRIES - 1);

    state_t        r_state;
    state_t        w_state_next;
    logic [AW-1:0] r_waddr;
    logic [AW-1:0] r_trig_addr;
    logic [AW:0]   r_smpl_cnt;
    logic [AW:0]   r_trig_cnt;
    logic          r_armed;
    logic          r_done;

    logic [AW:0]   w_tp_eff;
    logic [AW+1:0] w_arm_sum;
    logic          w_arm_hit;
    logic          w_start;
    logic          w_count_wr;
    logic          w_final;
    logic [AW-1:0] w_waddr_inc;

    // Post-trigger count clamped to 1..ENTRIES-1 so a capture always ends
    // and always leaves at least one pre-trigger sample.
    always_comb begin
        w_tp_eff = {1'b0, trig_pos};
        if (trig_pos == '0) begin
            w_tp_eff = (AW+1)'(1);
        end else if ({1'b0, trig_pos} >= LP_ENT1) begin
            w_tp_eff = LP_ENT1 - (AW+1)'(1);
        end
    end

    // Arm once the stored history plus the pending post-trigger samples fill
    // the RAM; wide sum so it cannot overflow. A trigger only counts while
    // armed, and the capture finishes on the tp_eff-th counted write.
    assign w_arm_sum   = {1'b0, r_smpl_cnt} + {1'b0, w_tp_eff} + (AW+2)'(1);
    assign w_arm_hit   = (w_arm_sum >= LP_ENT2);
    assign w_start     = run && !capture_done;
    assign w_count_wr  = wrt_smpl && triggered && r_armed;
    assign w_final     = w_count_wr && ((r_trig_cnt + (AW+1)'(1)) == w_tp_eff);
    assign w_waddr_inc = (r_waddr == LP_LAST) ? '0 : r_waddr + AW'(1);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and RAM write enable; WAIT_RD also waits out the pulse cycle,
    // since capture_done is only set by the edge that ends it.
    always_comb begin
        w_state_next = r_state;
        we           = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_start) begin
                    w_state_next = CAPTURE;
                end
            end
            CAPTURE: begin
                we = wrt_smpl;
                if (!run) begin
                    w_state_next = IDLE;
                end else if (w_final) begin
                    w_state_next = WAIT_RD;
                end
            end
            WAIT_RD: begin
                if (!capture_done && !r_done) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Address, counters, arm flag and done pulse; only strobe cycles advance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_waddr     <= '0;
            r_trig_addr <= '0;
            r_smpl_cnt  <= '0;
            r_trig_cnt  <= '0;
            r_armed     <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_waddr    <= '0;
                        r_smpl_cnt <= '0;
                        r_trig_cnt <= '0;
                        r_armed    <= 1'b0;
                    end
                end
                CAPTURE: begin
                    if (wrt_smpl) begin
                        r_waddr <= w_waddr_inc;
                        if (r_smpl_cnt != LP_ENT1) begin
                            r_smpl_cnt <= r_smpl_cnt + (AW+1)'(1);
                        end
                        if (w_arm_hit) begin
                            r_armed <= 1'b1;
                        end
                        if (w_count_wr) begin
                            r_trig_cnt <= r_trig_cnt + (AW+1)'(1);
                        end
                    end
                    // Abort outranks completion: no pulse once run drops
                    if (!run) begin
                        r_armed <= 1'b0;
                    end else if (w_final) begin
                        r_trig_addr <= r_waddr;
                        r_done      <= 1'b1;
                        r_armed     <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign waddr            = r_waddr;
    assign trig_addr        = r_trig_addr;
    assign armed            = r_armed;
    assign set_capture_done = r_done;

endmodule

// File: tb/tb_capture_ctrl.sv
// Self-checking bench for capture_ctrl (ENTRIES=16, AW=4): directed scenarios
// followed by randomized captures, all checked against a transaction-level model.
module tb_capture_ctrl;

    localparam int E  = 16;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          run = 1'b0;
    logic          capture_done = 1'b0;
    logic          wrt_smpl = 1'b0;
    logic          triggered = 1'b0;
    logic [AW-1:0] trig_pos = 4'd4;
    logic          we;
    logic [AW-1:0] waddr;
    logic          armed;
    logic          set_capture_done;
    logic [AW-1:0] trig_addr;

    int total = 0;
    int bad   = 0;

    // Model: phase 0 idle / 1 capturing / 2 waiting for readout
    int m_ph, m_n, m_post, m_addr, m_taddr;
    bit m_done;

    capture_ctrl #(.ENTRIES(E), .AW(AW)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .run              (run),
        .capture_done     (capture_done),
        .wrt_smpl         (wrt_smpl),
        .triggered        (triggered),
        .trig_pos         (trig_pos),
        .we               (we),
        .waddr            (waddr),
        .armed            (armed),
        .set_capture_done (set_capture_done),
        .trig_addr        (trig_addr)
    );

    always #5 clk = ~clk;

    function automatic int tp_eff();
        int t;
        t = int'(trig_pos);
        if (t == 0) return 1;
        if (t >= E) return E - 1;
        return t;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ph = 0; m_n = 0; m_post = 0; m_addr = 0; m_taddr = 0; m_done = 0;
    endtask

    // One clock: inputs are already applied (just after negedge)
    task automatic step();
        bit done_now, fin, arm_m;
        #1;
        chk("we", {31'd0, we}, {31'd0, (m_ph == 1) && wrt_smpl});
        done_now = m_done;
        m_done   = 0;
        fin      = 0;
        case (m_ph)
            0: if (run && !capture_done) begin
                m_ph = 1; m_n = 0; m_post = 0; m_addr = 0;
            end
            1: begin
                arm_m = (m_n + tp_eff() >= E);
                if (wrt_smpl) begin
                    if (triggered && arm_m) begin
                        m_post++;
                        if (m_post == tp_eff()) fin = 1;
                    end
                    m_n++;
                    m_addr = (m_addr + 1) % E;
                end
                if (!run) begin
                    m_ph = 0;
                end else if (fin) begin
                    m_ph    = 2;
                    m_taddr = (m_addr + E - 1) % E;
                    m_done  = 1;
                end
            end
            default: if (!capture_done && !done_now) m_ph = 0;
        endcase
        @(posedge clk);
        #1;
        if (done_now) capture_done = 1'b1;   // status flag set by the pulse
        chk("waddr", {28'd0, waddr}, m_addr);
        chk("armed", {31'd0, armed}, {31'd0, (m_ph == 1) && (m_n + tp_eff() >= E)});
        chk("done_pulse", {31'd0, set_capture_done}, {31'd0, m_done});
        chk("trig_addr", {28'd0, trig_addr}, m_taddr);
        @(negedge clk);
    endtask

    task automatic cyc(input bit r, input bit w, input bit t);
        run = r; wrt_smpl = w; triggered = t;
        step();
    endtask

    // Let the pulse land in capture_done, then the host clears it
    task automatic host_clear();
        cyc(1, 0, 0);
        capture_done = 1'b0;
        cyc(1, 0, 0);
    endtask

    initial begin
        int onset, cnt;
        model_reset();
        // Reset held with run/wrt_smpl active
        run = 1'b1; wrt_smpl = 1'b1;
        @(posedge clk); #1;
        chk("rst_we", {31'd0, we}, 0);
        chk("rst_armed", {31'd0, armed}, 0);
        chk("rst_waddr", {28'd0, waddr}, 0);
        chk("rst_done", {31'd0, set_capture_done}, 0);
        chk("rst_trig_addr", {28'd0, trig_addr}, 0);
        @(negedge clk);
        run = 1'b0; wrt_smpl = 1'b0;
        rst_n = 1'b1;

        // Arm point and full capture with wrap, trig_pos=4
        trig_pos = 4'd4;
        cyc(1, 0, 0);
        for (int i = 0; i < 12; i++) begin
            cyc(1, 1, 0);
            if (i == 10) chk("arm_pt_not_yet", {31'd0, armed}, 0);
        end
        chk("arm_pt_armed", {31'd0, armed}, 1);
        chk("arm_pt_waddr", {28'd0, waddr}, 12);
        for (int i = 12; i < 20; i++) cyc(1, 1, 0);
        chk("wrap_waddr", {28'd0, waddr}, 4);
        for (int i = 20; i < 24; i++) cyc(1, 1, 1);
        chk("full_done", {31'd0, set_capture_done}, 1);
        chk("full_trig_addr", {28'd0, trig_addr}, 7);
        for (int i = 0; i < 3; i++) cyc(1, 1, 1);      // WAIT_RD holds, run=1
        chk("wait_no_we", {31'd0, we}, 0);
        chk("wait_hold_addr", {28'd0, trig_addr}, 7);
        capture_done = 1'b0;
        cyc(1, 0, 0);
        cyc(1, 0, 0);
        chk("restart_waddr", {28'd0, waddr}, 0);

        // Early trigger: triggered from the first write
        for (int i = 0; i < 16; i++) cyc(1, 1, 1);
        chk("early_done", {31'd0, set_capture_done}, 1);
        chk("early_trig_addr", {28'd0, trig_addr}, 15);
        host_clear();

        // Sparse strobes every 3rd clock, trig_pos=3
        trig_pos = 4'd3;
        for (int i = 0; i < 90 && m_ph != 2; i++) cyc(1, (i % 3) == 2, i >= 40);
        chk("sparse_reached_wait", m_ph, 2);
        host_clear();

        // Abort at write 8
        trig_pos = 4'd4;
        for (int i = 0; i < 8; i++) cyc(1, 1, 1);
        cyc(0, 1, 1);
        chk("abort_armed", {31'd0, armed}, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0);
        chk("abort_no_pulse", {31'd0, set_capture_done}, 0);

        // trig_pos=0 clamps to one post-trigger sample
        trig_pos = 4'd0;
        cyc(1, 0, 0);
        for (int i = 0; i < 16; i++) cyc(1, 1, 1);
        chk("tp0_trig_addr", {28'd0, trig_addr}, 15);
        host_clear();

        // Randomized captures
        for (int k = 0; k < 10; k++) begin
            trig_pos = 4'($urandom_range(0, 15));
            onset = $urandom_range(0, 30);
            cnt = 0;
            for (int i = 0; i < 300; i++) begin
                if (m_ph == 2) begin
                    repeat ($urandom_range(1, 3)) cyc(1, $urandom_range(0, 1), 1);
                    capture_done = 1'b0;
                    cyc(1, 0, 0);
                    break;
                end
                cyc($urandom_range(0, 49) != 0, $urandom_range(0, 1), cnt >= onset);
                cnt++;
            end
        end

        // Asynchronous reset mid-capture
        trig_pos = 4'd5;
        capture_done = 1'b0;
        for (int i = 0; i < 14; i++) cyc(1, 1, 1);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("arst_waddr", {28'd0, waddr}, 0);
        chk("arst_armed", {31'd0, armed}, 0);
        chk("arst_done", {31'd0, set_capture_done}, 0);
        chk("arst_we", {31'd0, we}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run = 1'b0;
        cyc(0, 0, 0);
        cyc(0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
